// File: rtl/countdown_timer.sv
`default_nettype none
// ============================================================================
// countdown_timer : preset h:m:s value counts down once per second to 00:00:00
// Revision        : 1.0
// ============================================================================
module countdown_timer #(
  parameter int CLK_DIV   = 250,
  parameter int MAX_HOURS = 99
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] set_seconds,
  input  logic [7:0] set_minutes,
  input  logic [7:0] set_hours,
  input  logic       startStop,
  output logic [7:0] seconds,
  output logic [7:0] minutes,
  output logic [7:0] hours,
  output logic       running,
  output logic       done,
  output logic       expired
);

  localparam int            PW           = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] C_PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [7:0]    C_MAX_HOURS  = 8'(MAX_HOURS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    sec_q, sec_d;
  logic [7:0]    min_q, min_d;
  logic [7:0]    hr_q, hr_d;
  logic          ss_prev_q, ss_prev_d;
  logic          running_q, running_d;
  logic          done_q, done_d;
  logic          expired_q, expired_d;

  logic w_ss_edge;
  logic w_tick;
  logic w_nonzero;
  logic w_last_step;

  assign w_ss_edge   = startStop & ~ss_prev_q;
  assign w_tick      = (state_q == S_RUN) && (presc_q == C_PRESC_LAST);
  assign w_nonzero   = (sec_q != 8'd0) || (min_q != 8'd0) || (hr_q != 8'd0);
  assign w_last_step = (sec_q == 8'd1) && (min_q == 8'd0) && (hr_q == 8'd0);

  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    sec_d     = sec_q;
    min_d     = min_q;
    hr_d      = hr_q;
    ss_prev_d = startStop;
    expired_d = 1'b0;

    if (load) begin
      sec_d   = (set_seconds > 8'd59) ? 8'd59 : set_seconds;
      min_d   = (set_minutes > 8'd59) ? 8'd59 : set_minutes;
      hr_d    = (set_hours > C_MAX_HOURS) ? C_MAX_HOURS : set_hours;
      presc_d = '0;
      state_d = S_IDLE;
    end else if (w_ss_edge) begin
      // An edge wins over a coincident tick, so pausing on the last
      // prescaler cycle keeps that second pending.
      case (state_q)
        S_IDLE: begin
          if (w_nonzero) begin
            state_d = S_RUN;
            presc_d = '0;
          end
        end
        S_RUN:   state_d = S_PAUSE;
        S_PAUSE: state_d = S_RUN;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end else if (w_tick) begin
      presc_d = '0;
      if (sec_q != 8'd0) begin
        sec_d = sec_q - 8'd1;
      end else if (min_q != 8'd0) begin
        sec_d = 8'd59;
        min_d = min_q - 8'd1;
      end else begin
        sec_d = 8'd59;
        min_d = 8'd59;
        hr_d  = hr_q - 8'd1;
      end
      if (w_last_step) begin
        state_d   = S_DONE;
        expired_d = 1'b1;
      end
    end else if (state_q == S_RUN) begin
      presc_d = presc_q + PW'(1);
    end

    running_d = (state_d == S_RUN);
    done_d    = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      presc_q   <= '0;
      sec_q     <= 8'd0;
      min_q     <= 8'd0;
      hr_q      <= 8'd0;
      ss_prev_q <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      sec_q     <= sec_d;
      min_q     <= min_d;
      hr_q      <= hr_d;
      ss_prev_q <= ss_prev_d;
      running_q <= running_d;
      done_q    <= done_d;
      expired_q <= expired_d;
    end
  end

  assign seconds = sec_q;
  assign minutes = min_q;
  assign hours   = hr_q;
  assign running = running_q;
  assign done    = done_q;
  assign expired = expired_q;

endmodule
`default_nettype wire

// File: tb/tb_countdown_timer.sv
`default_nettype none
// ============================================================================
// tb_countdown_timer : scoreboard bench with a total-seconds reference model
// Revision           : 1.0
// ============================================================================
module tb_countdown_timer;

  localparam int CLK_DIV   = 4;
  localparam int MAX_HOURS = 99;

  localparam int C_IDLE  = 0;
  localparam int C_RUN   = 1;
  localparam int C_PAUSE = 2;
  localparam int C_DONE  = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       load = 1'b0;
  logic       startStop = 1'b0;
  logic [7:0] set_seconds = 8'd0;
  logic [7:0] set_minutes = 8'd0;
  logic [7:0] set_hours = 8'd0;
  logic [7:0] seconds, minutes, hours;
  logic       running, done, expired;

  always #5 clk = ~clk;

  countdown_timer #(
    .CLK_DIV   (CLK_DIV),
    .MAX_HOURS (MAX_HOURS)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .set_seconds (set_seconds),
    .set_minutes (set_minutes),
    .set_hours   (set_hours),
    .startStop   (startStop),
    .seconds     (seconds),
    .minutes     (minutes),
    .hours       (hours),
    .running     (running),
    .done        (done),
    .expired     (expired)
  );

  typedef struct packed {
    logic [7:0] h;
    logic [7:0] m;
    logic [7:0] s;
    logic       run;
    logic       dn;
    logic       ex;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: the remaining time is one integer of seconds.
  int   m_rem  = 0;
  int   m_mode = C_IDLE;
  int   m_sub  = 0;
  bit   m_prev = 1'b0;

  function automatic int sat(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  task automatic cycle(input logic rn, input logic ld, input logic ss,
                       input logic [7:0] s, input logic [7:0] mi, input logic [7:0] h);
    bit   edge_s;
    bit   ex;
    exp_t e;
    @(negedge clk);
    reset       = rn;
    load        = ld;
    startStop   = ss;
    set_seconds = s;
    set_minutes = mi;
    set_hours   = h;
    ex = 1'b0;
    if (!rn) begin
      m_rem  = 0;
      m_mode = C_IDLE;
      m_sub  = 0;
      m_prev = 1'b0;
    end else begin
      edge_s = ss && !m_prev;
      m_prev = ss;
      if (ld) begin
        m_rem  = sat(int'(h), MAX_HOURS) * 3600 + sat(int'(mi), 59) * 60 + sat(int'(s), 59);
        m_sub  = 0;
        m_mode = C_IDLE;
      end else if (edge_s) begin
        case (m_mode)
          C_IDLE:  if (m_rem != 0) begin m_mode = C_RUN; m_sub = 0; end
          C_RUN:   m_mode = C_PAUSE;
          C_PAUSE: m_mode = C_RUN;
          default: m_mode = C_IDLE;
        endcase
      end else if (m_mode == C_RUN) begin
        m_sub++;
        if (m_sub == CLK_DIV) begin
          m_sub = 0;
          m_rem--;
          if (m_rem == 0) begin
            m_mode = C_DONE;
            ex     = 1'b1;
          end
        end
      end
    end
    e.h   = 8'(m_rem / 3600);
    e.m   = 8'((m_rem % 3600) / 60);
    e.s   = 8'(m_rem % 60);
    e.run = (m_mode == C_RUN);
    e.dn  = (m_mode == C_DONE);
    e.ex  = ex;
    exp_q.push_back(e);
  endtask

  task automatic hold(input int n);
    repeat (n) cycle(1'b1, 1'b0, 1'b0, set_seconds, set_minutes, set_hours);
  endtask

  task automatic do_load(input logic [7:0] s, input logic [7:0] mi, input logic [7:0] h);
    cycle(1'b1, 1'b1, 1'b0, s, mi, h);
  endtask

  task automatic press();
    cycle(1'b1, 1'b0, 1'b1, set_seconds, set_minutes, set_hours);
    cycle(1'b1, 1'b0, 1'b0, set_seconds, set_minutes, set_hours);
  endtask

  // Monitor: every cycle the DUT presents a registered output set.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({hours, minutes, seconds, running, done, expired} !== e) begin
          errors++;
          $display("FAIL out_cmp t=%0t got h=%0d m=%0d s=%0d run=%0b done=%0b exp=%0b want h=%0d m=%0d s=%0d run=%0b done=%0b exp=%0b",
                   $time, hours, minutes, seconds, running, done, expired,
                   e.h, e.m, e.s, e.run, e.dn, e.ex);
        end
      end
    end
  end

  initial begin
    logic       rn, ld, ss;
    logic [7:0] rs, rm, rh;
    int         r;

    // Reset held: random load/startStop activity must not leak through.
    repeat (20) cycle(1'b0, 1'($urandom % 2), 1'($urandom % 2),
                      8'($urandom), 8'($urandom), 8'($urandom));
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);

    // 00:01:05 runs through the minute borrow to expiry.
    do_load(8'd5, 8'd1, 8'd0);
    press();
    hold(270);

    // Hour borrow, then a zero preset refuses to start.
    do_load(8'd0, 8'd0, 8'd1);
    press();
    hold(6);
    do_load(8'd0, 8'd0, 8'd0);
    press();
    hold(6);

    // Pause mid-second keeps the partial second.
    do_load(8'd10, 8'd0, 8'd0);
    cycle(1'b1, 1'b0, 1'b1, 8'd10, 8'd0, 8'd0);
    hold(2);
    cycle(1'b1, 1'b0, 1'b1, 8'd10, 8'd0, 8'd0);
    hold(100);
    press();
    hold(3);

    // Saturating preset.
    do_load(8'd75, 8'd60, 8'd200);
    hold(2);

    // Load beats a same-cycle edge; DONE acknowledged back to IDLE.
    do_load(8'd3, 8'd0, 8'd0);
    press();
    hold(3);
    cycle(1'b1, 1'b1, 1'b1, 8'd3, 8'd0, 8'd0);
    hold(2);
    press();
    hold(20);
    press();
    hold(3);

    // Reset mid-run.
    do_load(8'd0, 8'd2, 8'd0);
    press();
    hold(7);
    cycle(1'b0, 1'b0, 1'b0, 8'd0, 8'd2, 8'd0);
    hold(3);

    // Randomised traffic with short presets so expiry happens often.
    for (int i = 0; i < 3000; i++) begin
      r  = int'($urandom % 200);
      rn = (r != 0);
      ld = (r > 0 && r < 6);
      ss = (($urandom % 6) == 0) ? ~startStop : startStop;
      rs = 8'($urandom % 80);
      rm = (($urandom % 4) == 0) ? 8'($urandom % 70) : 8'd0;
      rh = (($urandom % 16) == 0) ? 8'($urandom) : 8'd0;
      cycle(rn, ld, ss, rs, rm, rh);
    end

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
